odd_even_seq_sorter: RTL

ODD_EVEN_SEQ_SORTER -- requirements
Module: odd_even_seq_sorter

---
 rtl/odd_even_seq_sorter.sv | 107 ++++++++++
 1 files changed

// File: rtl/odd_even_seq_sorter.sv
// Frame sorter: loads N elements, runs N odd-even transposition phases, then streams the sorted frame.
// Output appears N+1 cycles after the last element is accepted; upstream and downstream are both valid/ready, with no frame overlap.
module odd_even_seq_sorter #(
    parameter int N = 10,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         desc,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic         busy
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] LOAD  = 2'd0;
    localparam logic [1:0] SORT  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          desc_q;
    logic [W-1:0]  slot    [N];
    logic [W-1:0]  swapped [N];

    // One transposition phase; cnt doubles as the phase index, whose parity picks the pairs.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            swapped[i] = slot[i];
        end
        for (int i = 0; i < N - 1; i++) begin
            if (i[0] == cnt[0]) begin
                if (desc_q ? (slot[i] < slot[i+1]) : (slot[i] > slot[i+1])) begin
                    swapped[i]   = slot[i+1];
                    swapped[i+1] = slot[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= LOAD;
            cnt    <= '0;
            desc_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                slot[i] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        slot[cnt] <= in_data;
                        if (cnt == '0) begin
                            desc_q <= desc;
                        end
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= SORT;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                SORT: begin
                    for (int i = 0; i < N; i++) begin
                        slot[i] <= swapped[i];
                    end
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= DRAIN;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= LOAD;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= LOAD;
                end
            endcase
        end
    end

    assign in_ready  = (state == LOAD);
    assign busy      = (state == SORT) || (state == DRAIN);
    assign out_valid = (state == DRAIN);
    assign out_data  = out_valid ? slot[cnt] : '0;
    assign out_last  = out_valid && (cnt == LAST);

endmodule
